alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_if.sv | 24 ++
 rtl/alu_mc.sv | 183 ++++++++++++++++++
 tb/tb_alu_mc.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: operation request handshake in, result handshake out.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alufn;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             div_by_zero;

  modport master (
    output in_valid, alufn, data_a, data_b, out_ready,
    input  in_ready, out_valid, res, div_by_zero
  );

  modport slave (
    input  in_valid, alufn, data_a, data_b, out_ready,
    output in_ready, out_valid, res, div_by_zero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: latency-1 arithmetic/logic/compare/shift ops plus an iterative signed
// restoring divider that is only built when ALU_MC_DIV_EN is defined.
module alu_mc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst,
  input logic     clk_en,
  alu_mc_if.slave bus
);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpMul   = 4'b0010;
  localparam logic [3:0] OpDiv   = 4'b0011;
  localparam logic [3:0] OpCmpEq = 4'b0100;
  localparam logic [3:0] OpCmpLt = 4'b0101;
  localparam logic [3:0] OpCmpLe = 4'b0110;
  localparam logic [3:0] OpAnd   = 4'b1000;
  localparam logic [3:0] OpOr    = 4'b1001;
  localparam logic [3:0] OpXor   = 4'b1010;
  localparam logic [3:0] OpShl   = 4'b1100;
  localparam logic [3:0] OpShr   = 4'b1101;
  localparam logic [3:0] OpSra   = 4'b1110;

`ifdef ALU_MC_DIV_EN
  typedef enum logic [1:0] {StIdle, StDivRun, StHold} state_e;
`else
  typedef enum logic [0:0] {StIdle, StHold} state_e;
`endif

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;
  logic             in_ready, accept, busy;

`ifdef ALU_MC_DIV_EN
  assign busy = (state_q == StDivRun);
`else
  assign busy = 1'b0;
`endif

  assign in_ready = !busy && (!out_valid_q || bus.out_ready);
  assign accept   = clk_en && bus.in_valid && in_ready;
  assign shamt    = bus.data_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.alufn)
      OpAdd:   alu_res = bus.data_a + bus.data_b;
      OpSub:   alu_res = bus.data_a - bus.data_b;
      OpMul:   alu_res = bus.data_a * bus.data_b;
      OpDiv:   alu_res = '0;  // only reaches res when the divider is not built
      OpCmpEq: alu_res = WIDTH'(bus.data_a == bus.data_b);
      OpCmpLt: alu_res = WIDTH'($signed(bus.data_a) < $signed(bus.data_b));
      OpCmpLe: alu_res = WIDTH'($signed(bus.data_a) <= $signed(bus.data_b));
      OpAnd:   alu_res = bus.data_a & bus.data_b;
      OpOr:    alu_res = bus.data_a | bus.data_b;
      OpXor:   alu_res = bus.data_a ^ bus.data_b;
      OpShl:   alu_res = bus.data_a << shamt;
      OpShr:   alu_res = bus.data_a >> shamt;
      OpSra:   alu_res = $signed(bus.data_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MC_DIV_EN
  // dvd_q shifts the dividend magnitude out of the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0] dvd_q, dvd_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             neg_q, neg_d, zero_q, zero_d;
  logic             op_div, div_last, ge;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_nx, quo_nx, div_res;

  assign op_div   = (bus.alufn == OpDiv);
  assign div_last = busy && (cnt_q == SHW'(WIDTH - 1));
  assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
  assign ge       = (rem_sh >= {1'b0, dvs_q});
  assign rem_nx   = ge ? WIDTH'(rem_sh - {1'b0, dvs_q}) : rem_sh[WIDTH-1:0];
  assign quo_nx   = {dvd_q[WIDTH-2:0], ge};
  assign div_res  = zero_q ? '1 : (neg_q ? -quo_nx : quo_nx);

  always_comb begin
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    neg_d  = neg_q;
    zero_d = zero_q;
    if (clk_en) begin
      if (accept && op_div) begin
        dvd_d  = bus.data_a[WIDTH-1] ? -bus.data_a : bus.data_a;
        dvs_d  = bus.data_b[WIDTH-1] ? -bus.data_b : bus.data_b;
        rem_d  = '0;
        cnt_d  = '0;
        neg_d  = bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1];
        zero_d = (bus.data_b == '0);
      end else if (busy) begin
        dvd_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + SHW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      neg_q  <= neg_d;
      zero_q <= zero_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    dbz_d       = dbz_q;
    if (clk_en) begin
      if (busy) begin
`ifdef ALU_MC_DIV_EN
        if (div_last) begin
          state_d     = StHold;
          out_valid_d = 1'b1;
          res_d       = div_res;
          dbz_d       = zero_q;
        end
`endif
      end else if (accept) begin
        state_d     = StHold;
        out_valid_d = 1'b1;
        res_d       = alu_res;
        dbz_d       = 1'b0;
`ifdef ALU_MC_DIV_EN
        if (op_div) begin
          state_d     = StDivRun;
          out_valid_d = 1'b0;
          res_d       = res_q;
        end
`endif
      end else if (out_valid_q && bus.out_ready) begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.res         = res_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32; DIV expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
  localparam int unsigned W = 32;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_EQ  = 4'b0100;
  localparam logic [3:0] OP_LT  = 4'b0101;
  localparam logic [3:0] OP_LE  = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_SRA = 4'b1110;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alufn    = op;
    bus.data_a   = a;
    bus.data_b   = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Returns the number of edges from the accept edge to out_valid, stalling 3 cycles at stall_at.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int stall_at,
                         output int edges, output bit ready_seen);
    ready_seen = 1'b0;
    issue(OP_DIV, a, b);
    edges = 1;
    while (!bus.out_valid && edges < 200) begin
      if (bus.in_ready) ready_seen = 1'b1;
      if (edges == stall_at) begin
        clk_en = 1'b0;
        repeat (3) tick();
        clk_en = 1'b1;
        edges += 3;
      end else begin
        tick();
        edges++;
      end
    end
  endtask

  int edges;
  bit ready_seen;
  bit valid_seen;

  initial begin
    rst           = 1'b1;
    clk_en        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alufn     = OP_ADD;
    bus.data_a    = '0;
    bus.data_b    = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset res", 64'(bus.res), 64'd0);
    check("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
    rst = 1'b0;
    check("in_ready after reset", 64'(bus.in_ready), 64'd1);

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add wrap valid", 64'(bus.out_valid), 64'd1);
    check("add wrap res", 64'(bus.res), 64'h8000_0000);
    check("add dbz", 64'(bus.div_by_zero), 64'd0);
    issue(OP_SRA, 32'h8000_0000, 32'h0000_0024);
    check("sra", 64'(bus.res), 64'hF800_0000);
    issue(OP_SHR, 32'h8000_0000, 32'h0000_0024);
    check("shr", 64'(bus.res), 64'h0800_0000);
    issue(OP_SHL, 32'h0000_0001, 32'h0000_0021);
    check("shl", 64'(bus.res), 64'h0000_0002);
    issue(OP_SUB, 32'h0000_0000, 32'h0000_0001);
    check("sub", 64'(bus.res), 64'hFFFF_FFFF);
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
    check("mul wrap", 64'(bus.res), 64'h0000_0000);
    issue(OP_MUL, 32'hFFFF_FFFD, 32'h0000_0005);
    check("mul signed", 64'(bus.res), 64'hFFFF_FFF1);
    issue(OP_LT, 32'hFFFF_FFFF, 32'h0000_0001);
    check("cmplt signed", 64'(bus.res), 64'h1);
    issue(OP_LE, 32'h0000_0005, 32'h0000_0005);
    check("cmple equal", 64'(bus.res), 64'h1);
    issue(OP_EQ, 32'h0000_0003, 32'h0000_0004);
    check("cmpeq false", 64'(bus.res), 64'h0);
    issue(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    check("and", 64'(bus.res), 64'h0000_F000);
    issue(OP_OR, 32'h0000_00F0, 32'h0000_0F00);
    check("or", 64'(bus.res), 64'h0000_0FF0);
    issue(OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00);
    check("xor", 64'(bus.res), 64'h00FF_FF00);
    issue(4'b0111, 32'h1234_5678, 32'h1111_1111);
    check("undef op valid", 64'(bus.out_valid), 64'd1);
    check("undef op res", 64'(bus.res), 64'h0);
    tick();
    check("valid clears on out_ready", 64'(bus.out_valid), 64'd0);

    // Result held under backpressure while a new request waits.
    bus.out_ready = 1'b0;
    issue(OP_ADD, 32'd10, 32'd20);
    check("hold first res", 64'(bus.res), 64'd30);
    bus.in_valid = 1'b1;
    bus.alufn    = OP_ADD;
    bus.data_a   = 32'd1;
    bus.data_b   = 32'd1;
    check("in_ready low while held", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold valid", 64'(bus.out_valid), 64'd1);
      check("hold res", 64'(bus.res), 64'd30);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("held result consumed", 64'(bus.out_valid), 64'd0);

    // clk_en low freezes everything, including out_ready consumption and new requests.
    bus.out_ready = 1'b0;
    issue(OP_XOR, 32'h0000_00FF, 32'h0000_000F);
    clk_en        = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alufn     = OP_ADD;
    bus.data_a    = 32'd100;
    bus.data_b    = 32'd1;
    tick();
    tick();
    check("stall valid held", 64'(bus.out_valid), 64'd1);
    check("stall res held", 64'(bus.res), 64'h0000_00F0);
    clk_en       = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    check("consume after stall", 64'(bus.out_valid), 64'd0);

`ifdef ALU_MC_DIV_EN
    run_div(32'hFFFF_FFF9, 32'h0000_0002, -1, edges, ready_seen);
    check("div -7/2 latency", 64'(edges), 64'd33);
    check("div -7/2 res", 64'(bus.res), 64'hFFFF_FFFD);
    check("div -7/2 dbz", 64'(bus.div_by_zero), 64'd0);
    check("div in_ready low", 64'(ready_seen), 64'd0);
    run_div(32'h0000_0005, 32'h0000_0000, -1, edges, ready_seen);
    check("div 5/0 latency", 64'(edges), 64'd33);
    check("div 5/0 res", 64'(bus.res), 64'hFFFF_FFFF);
    check("div 5/0 dbz", 64'(bus.div_by_zero), 64'd1);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, -1, edges, ready_seen);
    check("div min/-1 res", 64'(bus.res), 64'h8000_0000);
    check("div min/-1 dbz", 64'(bus.div_by_zero), 64'd0);
    run_div(32'd100, 32'hFFFF_FFF9, 10, edges, ready_seen);
    check("div stall latency", 64'(edges), 64'd36);
    check("div 100/-7 res", 64'(bus.res), 64'hFFFF_FFF2);

    // Reset in the middle of a division discards it.
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check("div abort valid", 64'(bus.out_valid), 64'd0);
    check("div abort res", 64'(bus.res), 64'd0);
    rst = 1'b0;
    check("div abort in_ready", 64'(bus.in_ready), 64'd1);
    valid_seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.out_valid) valid_seen = 1'b1;
    end
    check("aborted div gives no result", 64'(valid_seen), 64'd0);
`else
    issue(OP_DIV, 32'd9, 32'd3);
    check("div off valid", 64'(bus.out_valid), 64'd1);
    check("div off res", 64'(bus.res), 64'd0);
    check("div off dbz", 64'(bus.div_by_zero), 64'd0);
    tick();
`endif

    // Reset while a result is held.
    bus.out_ready = 1'b0;
    issue(OP_ADD, 32'd5, 32'd6);
    check("pre-reset res", 64'(bus.res), 64'd11);
    rst = 1'b1;
    tick();
    check("reset clears valid", 64'(bus.out_valid), 64'd0);
    check("reset clears res", 64'(bus.res), 64'd0);
    rst = 1'b0;
    check("in_ready after second reset", 64'(bus.in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
